mem_bus_arbiter: RTL

- Shares the single line-granular memory bus (2-bit command, line address, BUS_SIZE data) between NUM_REQ cache-side requesters, for example two cache instances in a dual-CPU build.
- Grants one whole transaction at a time in round-robin order and forwards the winner's request to memory.
- Routes the memory response back to the winner only; non-granted requesters see C2_NOP and stall.
- Data paths are split (in/out/oe); any tri-state wrapper lives at top level.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_rr_pick.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the line-granular memory bus arbiter.
// Holds command encodings, the arbiter state type and the beat-count helper.
package mem_bus_pkg;

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Number of bus beats needed to move one cache line.
  function automatic int unsigned beats_f(input int unsigned line_bytes,
                                          input int unsigned bus_bits);
    return (line_bytes * 8) / bus_bits;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request after the last winner.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          valid_c
);

  int unsigned cand;

  // Scan last+1, last+2, ... wrapping, so the previous winner is checked last.
  always_comb begin : pick
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last) + i) % N;
      if (!valid_c && req[IW'(cand)]) begin
        valid_c            = 1'b1;
        idx_c              = IW'(cand);
        gnt_c[IW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-granular memory bus between NUM_REQ caches.
// One whole transaction (forward, wait, response) is owned by a single winner.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned MEM_ADDR_SIZE     = 19,
  parameter int unsigned BUS_SIZE          = 16,
  parameter int unsigned CACHE_OFFSET_SIZE = 4,
  parameter int unsigned CACHE_LINE_SIZE   = 16,
  parameter int unsigned NUM_REQ           = 2,
  parameter int unsigned TIMEOUT           = 255,
  localparam int unsigned A                = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*NUM_REQ-1:0]      req_command,
  input  logic [A*NUM_REQ-1:0]      req_address,
  input  logic [BUS_SIZE*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [2*NUM_REQ-1:0]      req_resp,
  output logic [BUS_SIZE-1:0]       req_rdata,
  output logic [1:0]                mem_command,
  output logic [A-1:0]              mem_address,
  output logic [BUS_SIZE-1:0]       mem_wdata,
  output logic                      mem_wdata_oe,
  input  logic [1:0]                mem_resp,
  input  logic [BUS_SIZE-1:0]       mem_rdata,
  output logic                      err
);

  localparam int unsigned BEATS  = beats_f(CACHE_LINE_SIZE, BUS_SIZE);
  localparam int unsigned BEAT_W = $clog2(BEATS) + 1;
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                tout_q, tout_d;
  logic                err_q, err_d;

  logic [1:0]          cmd_a  [NUM_REQ];
  logic [A-1:0]        addr_a [NUM_REQ];
  logic [BUS_SIZE-1:0] data_a [NUM_REQ];
  logic [NUM_REQ-1:0]  req_v;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  logic                resp_fire;
  logic                resp_forced;

  // Split the flattened requester buses into per-requester views.
  always_comb begin : unpack
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cmd_a[i]  = req_command[2*i +: 2];
      addr_a[i] = req_address[A*i +: A];
      data_a[i] = req_data[BUS_SIZE*i +: BUS_SIZE];
      req_v[i]  = (req_command[2*i +: 2] != C2_NOP);
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .req     (req_v),
    .last    (last_q),
    .gnt_c   (pick_gnt),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  always_comb begin : fsm_next
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    last_d     = last_q;
    cmd_d      = cmd_q;
    beat_cnt_d = beat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    tout_d     = tout_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_resp == C2_RESPONSE) err_d = 1'b1;
        if (pick_valid) begin
          state_d    = ST_FWD;
          grant_d    = pick_gnt;
          idx_d      = pick_idx;
          last_d     = pick_idx;
          cmd_d      = cmd_a[pick_idx];
          beat_cnt_d = '0;
        end
      end
      ST_FWD: begin
        // A vanished command or early response is a protocol error, but the beats still finish.
        if (mem_resp == C2_RESPONSE) err_d = 1'b1;
        if (cmd_a[idx_q] == C2_NOP) err_d = 1'b1;
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        if (cmd_q != C2_WRITE_LINE || beat_cnt_q == BEAT_W'(BEATS - 1)) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        if (mem_resp == C2_RESPONSE) begin
          state_d = ST_RESP;
          tout_d  = 1'b0;
        end else if (wait_cnt_d == WCNT_W'(TIMEOUT)) begin
          state_d = ST_RESP;
          tout_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        if (tout_q || mem_resp != C2_RESPONSE) begin
          state_d = ST_IDLE;
          grant_d = '0;
          tout_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin : regs
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      cmd_q      <= C2_NOP;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      tout_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cmd_q      <= cmd_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tout_q     <= tout_d;
      err_q      <= err_d;
    end
  end

  // Response is steered to the winner only; a timeout substitutes one empty response.
  assign resp_forced = (state_q == ST_RESP) && tout_q;
  assign resp_fire   = ((state_q == ST_WAIT) || (state_q == ST_RESP && !tout_q))
                       && (mem_resp == C2_RESPONSE);

  always_comb begin : out_mux
    mem_command  = C2_NOP;
    mem_address  = '0;
    mem_wdata    = '0;
    mem_wdata_oe = 1'b0;
    req_resp     = '0;
    req_rdata    = '0;
    if (state_q == ST_FWD) begin
      mem_command  = cmd_a[idx_q];
      mem_address  = addr_a[idx_q];
      mem_wdata    = data_a[idx_q];
      mem_wdata_oe = (cmd_q == C2_WRITE_LINE);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == idx_q && (resp_fire || resp_forced)) begin
        req_resp[2*i +: 2] = C2_RESPONSE;
      end
    end
    if (resp_fire) req_rdata = mem_rdata;
  end

  assign req_grant = grant_q;
  assign err       = err_q;

endmodule
